// File: rtl/serial_sipo_rx.sv
// serial_sipo_rx: LSB-first serial-to-parallel receiver with valid/ready output and sticky overrun.
// Define SIPO_PARITY_EN to receive and check a trailing even-parity bit per word.
module serial_sipo_rx #(
    parameter int BITS = 4
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            data,
    input  logic            data_en,
    input  logic            clr,
    output logic [BITS-1:0] PO,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            overrun,
    output logic            par_err
);
    localparam int CW = $clog2(BITS);
    localparam logic [CW-1:0] LAST = CW'(BITS - 1);

    typedef enum logic {S_DATA, S_PARITY} state_t;

    state_t          state, state_n;
    logic [BITS-1:0] sr, word;
    logic [CW-1:0]   cnt, cnt_n;
    logic            shift, complete, perr;

    always_comb begin
        state_n = state;
        cnt_n = cnt;
        shift = data_en && state == S_DATA;
`ifdef SIPO_PARITY_EN
        complete = data_en && state == S_PARITY;
        word = sr;
        perr = ^{sr, data};
        if (shift) begin
            cnt_n = cnt == LAST ? '0 : cnt + 1'b1;
            state_n = cnt == LAST ? S_PARITY : S_DATA;
        end else if (complete) begin
            state_n = S_DATA;
        end
`else
        complete = shift && cnt == LAST;
        word = {data, sr[BITS-1:1]};
        perr = 1'b0;
        if (shift) cnt_n = complete ? '0 : cnt + 1'b1;
`endif
    end

`ifndef SIPO_PARITY_EN
    // The last bit goes straight from data into the word, so sr[0] is never read here.
    logic unused_sr0;
    assign unused_sr0 = sr[0];
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= S_DATA;
            sr <= '0;
            cnt <= '0;
            PO <= '0;
            out_valid <= 1'b0;
            overrun <= 1'b0;
            par_err <= 1'b0;
        end else if (clr) begin
            state <= S_DATA;
            sr <= '0;
            cnt <= '0;
            out_valid <= 1'b0;
            overrun <= 1'b0;
            par_err <= 1'b0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            if (shift) sr <= {data, sr[BITS-1:1]};
            // A slot being consumed this cycle can take the new word without loss.
            if (complete && (!out_valid || out_ready)) begin
                PO <= word;
                out_valid <= 1'b1;
                par_err <= perr;
            end else begin
                if (out_valid && out_ready) out_valid <= 1'b0;
                if (complete) overrun <= 1'b1;
            end
        end
    end
endmodule
